// File: rtl/z80_pad_bridge.sv
// rtl/z80_pad_bridge.sv - Z80 core to user-pad bridge: registered outputs, input synchronizers, wait-state generator
module z80_pad_bridge #(
  parameter int MEM_WAIT    = 0,
  parameter int IO_WAIT     = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [35:0] io_in,
  output logic [35:0] io_out,
  output logic [35:0] io_oeb,
  input  logic [7:0]  core_ctrl_n,
  input  logic [15:0] core_addr,
  input  logic [7:0]  core_dout,
  input  logic        core_doe,
  output logic [7:0]  core_din,
  output logic        core_wait_n,
  output logic        core_int_n,
  output logic        core_nmi_n,
  output logic        core_busrq_n
);

  localparam logic [3:0] MEM_CNT = 4'(MEM_WAIT);
  localparam logic [3:0] IO_CNT  = 4'(IO_WAIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } wait_state_t;

  // Board routing of the data bus: result bit k drives io[24+k].
  function automatic logic [7:0] pin_perm(input logic [7:0] d);
    pin_perm = {d[1], d[0], d[7], d[2], d[6], d[5], d[3], d[4]};
  endfunction

  function automatic logic [7:0] pin_unperm(input logic [7:0] p);
    pin_unperm = {p[5], p[3], p[2], p[0], p[1], p[4], p[7], p[6]};
  endfunction

  logic [7:0]  ctrl_q;
  logic [15:0] addr_q;
  logic [7:0]  dout_q;
  logic        doe_q;

  logic [3:0]  ctrl_sync [SYNC_STAGES];
  logic [7:0]  data_sync [SYNC_STAGES];

  wait_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        gen_wait_n_q, gen_wait_n_d;
  logic        mreq_prev_q, iorq_prev_q;

  logic        mreq_n, iorq_n, rfsh_n;
  logic        iorq_fall, mreq_fall;
  logic        unused_io;

  assign mreq_n    = core_ctrl_n[1];
  assign iorq_n    = core_ctrl_n[2];
  assign rfsh_n    = core_ctrl_n[5];
  assign unused_io = ^io_in[23:0];

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ctrl_q <= 8'hFF;
      addr_q <= 16'h0000;
      dout_q <= 8'h00;
      doe_q  <= 1'b0;
    end else begin
      ctrl_q <= core_ctrl_n;
      addr_q <= core_addr;
      dout_q <= core_dout;
      doe_q  <= core_doe;
    end
  end

  assign io_out = {4'h0, pin_perm(dout_q), addr_q, ctrl_q};
  assign io_oeb = {4'hF, {8{~doe_q}}, 24'h000000};

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        ctrl_sync[i] <= 4'hF;
        data_sync[i] <= 8'h00;
      end
    end else begin
      ctrl_sync[0] <= io_in[35:32];
      data_sync[0] <= io_in[31:24];
      for (int i = 1; i < SYNC_STAGES; i++) begin
        ctrl_sync[i] <= ctrl_sync[i-1];
        data_sync[i] <= data_sync[i-1];
      end
    end
  end

  assign core_din     = pin_unperm(data_sync[SYNC_STAGES-1]);
  assign core_int_n   = ctrl_sync[SYNC_STAGES-1][1];
  assign core_nmi_n   = ctrl_sync[SYNC_STAGES-1][2];
  assign core_busrq_n = ctrl_sync[SYNC_STAGES-1][3];
  assign core_wait_n  = ctrl_sync[SYNC_STAGES-1][0] & gen_wait_n_q;

  // Refresh cycles are excluded here so they can never start a wait.
  assign iorq_fall = iorq_prev_q & ~iorq_n;
  assign mreq_fall = mreq_prev_q & ~mreq_n & rfsh_n;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      gen_wait_n_q <= 1'b1;
      mreq_prev_q  <= 1'b1;
      iorq_prev_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      gen_wait_n_q <= gen_wait_n_d;
      mreq_prev_q  <= mreq_n;
      iorq_prev_q  <= iorq_n;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (iorq_fall) begin
          cnt_d   = IO_CNT;
          state_d = (IO_CNT != 4'd0) ? COUNT : HOLD;
        end else if (mreq_fall) begin
          cnt_d   = MEM_CNT;
          state_d = (MEM_CNT != 4'd0) ? COUNT : HOLD;
        end
      end
      COUNT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = HOLD;
      end
      HOLD: begin
        // Stay parked until the bus cycle ends so one cycle gets one wait burst.
        if (mreq_n && iorq_n) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    gen_wait_n_d = (state_d != COUNT);
  end

endmodule

// File: tb/tb_z80_pad_bridge.sv
// tb/tb_z80_pad_bridge.sv - randomized bench for z80_pad_bridge against a cycle-level reference model
module tb_z80_pad_bridge;

  localparam int MW [2] = '{2, 5};
  localparam int IW [2] = '{1, 0};
  localparam int SS [2] = '{2, 3};
  // IO_POS[j] = pad index (minus 24) carrying data bit j
  localparam int IO_POS [8] = '{6, 7, 4, 1, 0, 2, 3, 5};

  logic        clk;
  logic        rst;
  logic [35:0] io_in;
  logic [7:0]  ctrl;
  logic [15:0] addr;
  logic [7:0]  dout;
  logic        doe;

  logic [35:0] a_io_out, a_io_oeb, b_io_out, b_io_oeb;
  logic [7:0]  a_core_din, b_core_din;
  logic        a_core_wait_n, a_core_int_n, a_core_nmi_n, a_core_busrq_n;
  logic        b_core_wait_n, b_core_int_n, b_core_nmi_n, b_core_busrq_n;

  int n_cmp, n_bad;
  int lo_a, lo_b;
  bit chk_en;

  logic [35:0] m_out, m_oeb;
  logic [11:0] hist [2][8];
  bit          busy [2];
  int          left [2];
  bit          prev_m, prev_i, fall_i, fall_m;

  z80_pad_bridge #(.MEM_WAIT(2), .IO_WAIT(1), .SYNC_STAGES(2)) u_dut_a (
    .wb_clk_i(clk), .wb_rst_i(rst), .io_in(io_in), .io_out(a_io_out), .io_oeb(a_io_oeb),
    .core_ctrl_n(ctrl), .core_addr(addr), .core_dout(dout), .core_doe(doe),
    .core_din(a_core_din), .core_wait_n(a_core_wait_n), .core_int_n(a_core_int_n),
    .core_nmi_n(a_core_nmi_n), .core_busrq_n(a_core_busrq_n)
  );

  z80_pad_bridge #(.MEM_WAIT(5), .IO_WAIT(0), .SYNC_STAGES(3)) u_dut_b (
    .wb_clk_i(clk), .wb_rst_i(rst), .io_in(io_in), .io_out(b_io_out), .io_oeb(b_io_oeb),
    .core_ctrl_n(ctrl), .core_addr(addr), .core_dout(dout), .core_doe(doe),
    .core_din(b_core_din), .core_wait_n(b_core_wait_n), .core_int_n(b_core_int_n),
    .core_nmi_n(b_core_nmi_n), .core_busrq_n(b_core_busrq_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] to_pins(input logic [7:0] d);
    logic [7:0] p;
    p = 8'h00;
    for (int j = 0; j < 8; j++) p[IO_POS[j]] = d[j];
    return p;
  endfunction

  function automatic logic [7:0] from_pins(input logic [7:0] p);
    logic [7:0] d;
    for (int j = 0; j < 8; j++) d[j] = p[IO_POS[j]];
    return d;
  endfunction

  task automatic check_eq(input string tag, input logic [35:0] got, input logic [35:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: each accepted strobe edge owes N low cycles, then the generator
  // is deaf until both strobes are back high; pads appear S cycles late.
  always @(posedge clk) begin
    if (rst) begin
      m_out  = 36'h0_0000_00FF;
      m_oeb  = 36'hF_FF00_0000;
      prev_m = 1'b1;
      prev_i = 1'b1;
      for (int d = 0; d < 2; d++) begin
        busy[d] = 1'b0;
        left[d] = 0;
        for (int k = 0; k < 8; k++) hist[d][k] = 12'hF00;
      end
    end else begin
      fall_i = prev_i && !ctrl[2];
      fall_m = prev_m && !ctrl[1] && ctrl[5];
      for (int d = 0; d < 2; d++) begin
        if (busy[d] && left[d] == 0) begin
          if (ctrl[1] && ctrl[2]) busy[d] = 1'b0;
        end else if (busy[d]) begin
          left[d] = left[d] - 1;
        end else if (fall_i) begin
          busy[d] = 1'b1;
          left[d] = IW[d];
        end else if (fall_m) begin
          busy[d] = 1'b1;
          left[d] = MW[d];
        end
        for (int k = 7; k > 0; k--) hist[d][k] = hist[d][k-1];
        hist[d][0] = {io_in[35:32], io_in[31:24]};
      end
      prev_m = ctrl[1];
      prev_i = ctrl[2];
      m_out  = {4'h0, to_pins(dout), addr, ctrl};
      m_oeb  = {4'hF, doe ? 8'h00 : 8'hFF, 24'h000000};
    end
  end

  task automatic check_all();
    logic [11:0] ha, hb;
    ha = hist[0][SS[0]-1];
    hb = hist[1][SS[1]-1];
    check_eq("a_io_out", a_io_out, m_out);
    check_eq("a_io_oeb", a_io_oeb, m_oeb);
    check_eq("a_core_din", 36'(a_core_din), 36'(from_pins(ha[7:0])));
    check_eq("a_core_wait_n", 36'(a_core_wait_n), 36'(ha[8] && !(busy[0] && left[0] > 0)));
    check_eq("a_core_int_n", 36'(a_core_int_n), 36'(ha[9]));
    check_eq("a_core_nmi_n", 36'(a_core_nmi_n), 36'(ha[10]));
    check_eq("a_core_busrq_n", 36'(a_core_busrq_n), 36'(ha[11]));
    check_eq("b_io_out", b_io_out, m_out);
    check_eq("b_io_oeb", b_io_oeb, m_oeb);
    check_eq("b_core_din", 36'(b_core_din), 36'(from_pins(hb[7:0])));
    check_eq("b_core_wait_n", 36'(b_core_wait_n), 36'(hb[8] && !(busy[1] && left[1] > 0)));
    check_eq("b_core_int_n", 36'(b_core_int_n), 36'(hb[9]));
    check_eq("b_core_nmi_n", 36'(b_core_nmi_n), 36'(hb[10]));
    check_eq("b_core_busrq_n", 36'(b_core_busrq_n), 36'(hb[11]));
  endtask

  always @(negedge clk) begin
    if (chk_en) check_all();
  end

  task automatic step();
    @(negedge clk);
    if (!a_core_wait_n) lo_a++;
    if (!b_core_wait_n) lo_b++;
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_bad = 0; chk_en = 1'b0;
    rst = 1'b1; ctrl = 8'hFF; addr = 16'h0000; dout = 8'h00; doe = 1'b0;
    io_in = {4'hF, 32'h0000_0000};
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_ctrl", 36'(a_io_out[7:0]), 36'h0FF);
    check_eq("rst_addr", 36'(a_io_out[23:8]), 36'h0);
    check_eq("rst_oeb", a_io_oeb, 36'hF_FF00_0000);
    check_eq("rst_wait", 36'(a_core_wait_n), 36'h1);
    check_eq("rst_din", 36'(b_core_din), 36'h0);
    @(posedge clk); #1;

    dout = 8'hA5; doe = 1'b1;
    @(negedge clk);
    check_eq("perm_lat_oeb", 36'(a_io_oeb[31:24]), 36'hFF);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("perm_data", 36'(a_io_out[31:24]), 36'h74);
    check_eq("perm_oeb", 36'(a_io_oeb[31:24]), 36'h00);
    io_in[31:24] = 8'h74;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("din_lat1", 36'(a_core_din), 36'h00);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("din_a", 36'(a_core_din), 36'hA5);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("din_b", 36'(b_core_din), 36'hA5);
    @(posedge clk); #1;
    doe = 1'b0;
    steps(3);

    // Memory cycle with a strobe bounce during the count
    lo_a = 0; lo_b = 0;
    ctrl = 8'hFD;
    step();
    ctrl = 8'hFF;
    step();
    ctrl = 8'hFD;
    steps(12);
    check_eq("mem_wait_a", 36'(lo_a), 36'd2);
    check_eq("mem_wait_b", 36'(lo_b), 36'd5);
    ctrl = 8'hFF;
    steps(3);

    lo_a = 0; lo_b = 0;
    ctrl = 8'hDD;
    steps(10);
    check_eq("rfsh_wait_a", 36'(lo_a), 36'd0);
    check_eq("rfsh_wait_b", 36'(lo_b), 36'd0);
    ctrl = 8'hFF;
    steps(3);

    lo_a = 0; lo_b = 0;
    ctrl = 8'hF9;
    steps(10);
    check_eq("io_wait_a", 36'(lo_a), 36'd1);
    check_eq("io_wait_b", 36'(lo_b), 36'd0);
    ctrl = 8'hFF;
    steps(3);

    io_in[32] = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("ext_wait_lat", 36'(a_core_wait_n), 36'h1);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("ext_wait_a", 36'(a_core_wait_n), 36'h0);
    check_eq("ext_wait_b_lat", 36'(b_core_wait_n), 36'h1);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("ext_wait_b", 36'(b_core_wait_n), 36'h0);
    @(posedge clk); #1;
    io_in[32] = 1'b1;
    steps(4);

    // Reset lands on the second cycle of a 5-cycle count
    lo_a = 0; lo_b = 0;
    ctrl = 8'hFD;
    step();
    step();
    rst = 1'b1; ctrl = 8'hFF;
    step();
    @(negedge clk);
    check_eq("midrst_wait_b", 36'(b_core_wait_n), 36'h1);
    check_eq("midrst_cnt_b", 36'(lo_b), 36'd2);
    @(posedge clk); #1;
    rst = 1'b0;
    steps(2);
    lo_a = 0; lo_b = 0;
    ctrl = 8'hFD;
    steps(12);
    check_eq("postrst_wait_b", 36'(lo_b), 36'd5);
    check_eq("postrst_wait_a", 36'(lo_a), 36'd2);
    ctrl = 8'hFF;
    steps(3);

    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0) ctrl[1] = ~ctrl[1];
      if ($urandom_range(0, 5) == 0) ctrl[2] = ~ctrl[2];
      ctrl[5] = ($urandom_range(0, 7) != 0);
      ctrl[0] = $urandom_range(0, 1);
      ctrl[4:3] = 2'($urandom_range(0, 3));
      ctrl[7:6] = 2'($urandom_range(0, 3));
      addr = 16'($urandom);
      dout = 8'($urandom);
      doe = $urandom_range(0, 1);
      io_in[23:0] = 24'($urandom);
      io_in[31:24] = 8'($urandom);
      for (int k = 32; k < 36; k++) io_in[k] = ($urandom_range(0, 4) != 0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
